// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS sequencing controller.
// Walks the shared-memory/shared-ALU datapath through fetch, decode, execute,
// memory and writeback. It drives every select/enable line as a Moore decode
// of the state, waits on the memory-ready handshake, and counts retired
// instructions.
module multicycle_control_fsm #(
  parameter int         CNT_W      = 32,
  parameter logic [1:0] JAL_REGDST = 2'b10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic [1:0]       regdst,
  output logic [1:0]       memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             trap,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTEXEC   = 4'd6,
    RTWB     = 4'd7,
    BEQ      = 4'd8,
    JUMP     = 4'd9,
    JAL      = 4'd10,
    ADDIEXEC = 4'd11,
    ADDIWB   = 4'd12,
    JR       = 4'd13,
    ILLEGAL  = 4'd14,
    IDLE     = 4'd15
  } state_t;

  state_t state, state_next;
  logic   retire;

  // The branch comparison is resolved inside the datapath (pcwritecond & zero),
  // so the controller never needs the flag itself.
  logic unused_zero;
  assign unused_zero = zero;

  assign state_o = state;

  // State register; reset parks the sequencer in IDLE with every output low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: opcode/funct are only looked at in DECODE and MEMADR.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     state_next = FETCH;
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = (funct == FN_JR) ? JR : RTEXEC;
          OP_BEQ:       state_next = BEQ;
          OP_J:         state_next = JUMP;
          OP_JAL:       state_next = JAL;
          OP_ADDI:      state_next = ADDIEXEC;
          default:      state_next = ILLEGAL;
        endcase
      end
      MEMADR:   state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    if (mem_ready) state_next = MEMWB;
      MEMWR:    if (mem_ready) state_next = FETCH;
      RTEXEC:   state_next = RTWB;
      ADDIEXEC: state_next = ADDIWB;
      MEMWB, RTWB, BEQ, JUMP, JAL, ADDIWB, JR:
                state_next = FETCH;
      ILLEGAL:  state_next = ILLEGAL;
      default:  state_next = FETCH;
    endcase
  end

  // Moore output decode; only irwrite/pcwrite in FETCH follow mem_ready.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 2'b00;
    memtoreg    = 2'b00;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    pcsource    = 2'b00;
    case (state)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      DECODE: alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 2'b01;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      RTEXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTWB: begin
        regwrite = 1'b1;
        regdst   = 2'b01;
      end
      BEQ: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
      // PC still holds PC+4 here, so r31 captures the return address while
      // the PC is loaded with the jump target.
      JAL: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
        regwrite = 1'b1;
        regdst   = JAL_REGDST;
        memtoreg = 2'b10;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite = 1'b1;
      JR: begin
        pcwrite  = 1'b1;
        pcsource = 2'b11;
      end
      default: ;
    endcase
  end

  // An instruction retires on the edge that leaves its last state for FETCH.
  always_comb begin
    retire = 1'b0;
    case (state)
      MEMWB, MEMWR, RTWB, BEQ, JUMP, JAL, ADDIWB, JR:
        retire = (state_next == FETCH);
      default: retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // Sticky illegal-opcode flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     trap <= 1'b0;
    else if (state_next == ILLEGAL) trap <= 1'b1;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: reset, lw with memory
// stalls, a table of single instructions, random instruction streams against
// an instruction-level model, illegal opcode hold and asynchronous reset.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, alusrca, trap;
  logic [1:0] regdst, memtoreg, alusrcb, aluop, pcsource;
  logic [3:0] state_o;
  logic [CNT_W-1:0] instret;

  multicycle_control_fsm #(.CNT_W(CNT_W), .JAL_REGDST(2'b10)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
    .trap(trap), .state_o(state_o), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, BEQ_OP = 6'h04, J_OP = 6'h02;
  localparam logic [5:0] JAL_OP = 6'h03, ADDI = 6'h08, RT = 6'h00;

  int checks = 0;
  int errors = 0;

  logic [17:0] dut_ctrl;
  assign dut_ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite,
                     alusrca, regdst, memtoreg, alusrcb, aluop, pcsource};

  // Instruction-level model: queue of upcoming state numbers plus counters.
  int q[$];
  logic [CNT_W-1:0] m_cnt;
  int s_state;
  logic [17:0] s_ctrl;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input int pcw, pcwc, io, mrd, mwr, irw, rw, asa,
                                     input int rd, mtr, asb, aop, pcs);
    return {pcw[0], pcwc[0], io[0], mrd[0], mwr[0], irw[0], rw[0], asa[0],
            rd[1:0], mtr[1:0], asb[1:0], aop[1:0], pcs[1:0]};
  endfunction

  // Control word each state must present.
  function automatic logic [17:0] exp_ctrl(input int s, input int mr);
    case (s)
      0:  return mk(mr,0,0,1,0,mr,0,0, 0,0,1,0,0);
      1:  return mk(0,0,0,0,0,0,0,0, 0,0,3,0,0);
      2:  return mk(0,0,0,0,0,0,0,1, 0,0,2,0,0);
      3:  return mk(0,0,1,1,0,0,0,0, 0,0,0,0,0);
      4:  return mk(0,0,0,0,0,0,1,0, 0,1,0,0,0);
      5:  return mk(0,0,1,0,1,0,0,0, 0,0,0,0,0);
      6:  return mk(0,0,0,0,0,0,0,1, 0,0,0,2,0);
      7:  return mk(0,0,0,0,0,0,1,0, 1,0,0,0,0);
      8:  return mk(0,1,0,0,0,0,0,1, 0,0,0,1,1);
      9:  return mk(1,0,0,0,0,0,0,0, 0,0,0,0,2);
      10: return mk(1,0,0,0,0,0,1,0, 2,2,0,0,2);
      11: return mk(0,0,0,0,0,0,0,1, 0,0,2,0,0);
      12: return mk(0,0,0,0,0,0,1,0, 0,0,0,0,0);
      13: return mk(1,0,0,0,0,0,0,0, 0,0,0,0,3);
      default: return '0;
    endcase
  endfunction

  // States an instruction visits after DECODE.
  task automatic load_path(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      LW:     q = '{2, 3, 4};
      SW:     q = '{2, 5};
      RT:     if (fn == 6'h08) q = '{13}; else q = '{6, 7};
      BEQ_OP: q = '{8};
      J_OP:   q = '{9};
      JAL_OP: q = '{10};
      ADDI:   q = '{11, 12};
      default: q = '{14};
    endcase
  endtask

  task automatic advance(input logic [5:0] op, input logic [5:0] fn, input bit mr);
    int cur;
    cur = q[0];
    if ((cur == 0 || cur == 3 || cur == 5) && !mr) return;
    void'(q.pop_front());
    case (cur)
      15: q.push_back(0);
      0:  q.push_back(1);
      1:  load_path(op, fn);
      14: q.push_back(14);
      default: ;
    endcase
    if (q.size() == 0) begin
      q.push_back(0);
      m_cnt = m_cnt + 1'b1;
    end
  endtask

  task automatic model_reset();
    q.delete();
    q.push_back(15);
    m_cnt = '0;
  endtask

  // One clock: drive at negedge, check before the next posedge, step the model.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input bit z, input bit mr);
    @(negedge clk);
    opcode = op; funct = fn; zero = z; mem_ready = mr;
    #1;
    s_state = int'(state_o);
    s_ctrl  = dut_ctrl;
    chk("state", state_o, q[0]);
    chk("ctrl", dut_ctrl, exp_ctrl(q[0], int'(mr)));
    chk("instret", instret, m_cnt);
    chk("trap", trap, (q[0] == 14));
    advance(op, fn, mr);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    opcode = '0; funct = '0; zero = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_state", state_o, 4'd15);
      chk("rst_ctrl", dut_ctrl, 18'd0);
      chk("rst_instret", instret, 0);
      chk("rst_trap", trap, 1'b0);
    end
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    bit          z;
    int          cycles;
    int          term;
    logic [17:0] tctrl;
  } vec_t;

  function automatic vec_t v(input string n, input logic [5:0] op, input logic [5:0] fn,
                             input bit z, input int cyc, input int term, input logic [17:0] c);
    vec_t r;
    r.name = n; r.op = op; r.fn = fn; r.z = z; r.cycles = cyc; r.term = term; r.tctrl = c;
    return r;
  endfunction

  vec_t tbl[10];

  task automatic pick(output logic [5:0] op, output logic [5:0] fn);
    int r;
    r = int'($urandom_range(0, 7));
    fn = 6'($urandom_range(0, 63));
    case (r)
      0: op = LW;
      1: op = SW;
      2: begin op = RT; if (fn == 6'h08) fn = 6'h20; end
      3: begin op = RT; fn = 6'h08; end
      4: op = BEQ_OP;
      5: op = J_OP;
      6: op = JAL_OP;
      default: op = ADDI;
    endcase
  endtask

  initial begin
    bit mrs[10];
    int irw_cnt, rw_cnt;

    tbl[0] = v("add",   RT,     6'h20, 0, 4, 7,  mk(0,0,0,0,0,0,1,0, 1,0,0,0,0));
    tbl[1] = v("jr",    RT,     6'h08, 0, 3, 13, mk(1,0,0,0,0,0,0,0, 0,0,0,0,3));
    tbl[2] = v("jal",   JAL_OP, 6'h00, 0, 3, 10, mk(1,0,0,0,0,0,1,0, 2,2,0,0,2));
    tbl[3] = v("beq_z0",BEQ_OP, 6'h00, 0, 3, 8,  mk(0,1,0,0,0,0,0,1, 0,0,0,1,1));
    tbl[4] = v("beq_z1",BEQ_OP, 6'h00, 1, 3, 8,  mk(0,1,0,0,0,0,0,1, 0,0,0,1,1));
    tbl[5] = v("sw",    SW,     6'h00, 0, 4, 5,  mk(0,0,1,0,1,0,0,0, 0,0,0,0,0));
    tbl[6] = v("j",     J_OP,   6'h00, 0, 3, 9,  mk(1,0,0,0,0,0,0,0, 0,0,0,0,2));
    tbl[7] = v("addi",  ADDI,   6'h00, 0, 4, 12, mk(0,0,0,0,0,0,1,0, 0,0,0,0,0));
    tbl[8] = v("lw",    LW,     6'h00, 0, 5, 4,  mk(0,0,0,0,0,0,1,0, 0,1,0,0,0));
    tbl[9] = v("sub",   RT,     6'h22, 0, 4, 7,  mk(0,0,0,0,0,0,1,0, 1,0,0,0,0));

    // Reset, then lw with 3 stalled FETCH cycles and 2 stalled MEMRD cycles.
    do_reset();
    step(LW, 6'h00, 0, 1'b1);               // IDLE
    mrs = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};   // FETCH x4, DECODE, MEMADR, MEMRD x3, MEMWB
    irw_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(LW, 6'h00, 0, mrs[i]);
      irw_cnt += int'(irwrite);
      rw_cnt  += int'(regwrite);
    end
    chk("lw_irwrite_pulses", irw_cnt, 1);
    chk("lw_regwrite_cycles", rw_cnt, 1);
    chk("lw_last_state", s_state, 4);

    // Table of single instructions with mem_ready held high.
    for (int i = 0; i < 10; i++) begin
      int n, prev_s;
      logic [17:0] prev_c;
      bit done;
      n = 0; prev_s = -1; prev_c = '0; done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        step(tbl[i].op, tbl[i].fn, tbl[i].z, 1'b1);
        prev_s = s_state; prev_c = s_ctrl; n++;
        if (s_state inside {4, 5, 7, 8, 9, 10, 12, 13}) done = 1;
      end
      if (!done) chk({tbl[i].name, "_timeout"}, 0, 1);
      chk({tbl[i].name, "_cycles"}, n, tbl[i].cycles);
      chk({tbl[i].name, "_term_state"}, prev_s, tbl[i].term);
      chk({tbl[i].name, "_term_ctrl"}, prev_c, tbl[i].tctrl);
    end

    // Random instruction stream with random stalls and stray mem_ready.
    begin
      logic [CNT_W-1:0] target;
      logic [5:0] op, fn;
      int cyc;
      target = m_cnt + 150;
      op = LW; fn = 6'h00; cyc = 0;
      while ((m_cnt != target || q[0] != 0) && cyc < 5000) begin
        if (q[0] == 0) pick(op, fn);
        step(op, fn, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        cyc++;
      end
      if (cyc >= 5000) chk("random_timeout", 0, 1);
    end

    // Illegal opcode: trap held, counter frozen.
    for (int i = 0; i < 12; i++) step(6'h3f, 6'h00, 0, 1'b1);
    chk("illegal_state", state_o, 4'd14);
    chk("illegal_trap", trap, 1'b1);

    // Asynchronous reset in the middle of a stalled lw read.
    do_reset();
    for (int i = 0; i < 4; i++) step(LW, 6'h00, 0, 1'b1);   // IDLE FETCH DECODE MEMADR
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    chk("pre_rst_state", state_o, 4'd3);
    chk("pre_rst_memread", memread, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_rst_state", state_o, 4'd15);
    chk("async_rst_memread", memread, 1'b0);
    chk("async_rst_ctrl", dut_ctrl, 18'd0);
    chk("async_rst_instret", instret, 0);
    model_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    step(LW, 6'h00, 0, 1'b1);
    step(LW, 6'h00, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
